// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared types for the cache memory-port arbiter
package cache_bus_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } arb_state_e;

  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - SRAM-like request/response bus shared by caches and memory port
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/owner_fifo.sv
// rtl/owner_fifo.sv - in-order FIFO of 1-bit transaction owners
module owner_fifo
  import cache_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  owner_e                     push_owner,
  input  logic                       pop,
  output owner_e                     head_owner,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  owner_e           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_owner;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_owner = mem[rd_ptr];
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one memory port between icache and dcache
module cache_mem_arbiter
  import cache_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  cache_mem_arbiter_if.slave  i_bus,
  cache_mem_arbiter_if.slave  d_bus,
  cache_mem_arbiter_if.master m_bus,
  output logic                busy,
  output logic                proto_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e       state;
  arb_state_e       state_nxt;
  owner_e           last_grant;
  owner_e           push_owner;
  owner_e           head_owner;
  logic             fwd_req;
  logic             accept;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  // The icache never writes, so its write-side fields are ignored.
  logic unused_icache_fields;
  assign unused_icache_fields = &{1'b0, i_bus.wr, i_bus.size, i_bus.wdata};

  assign fwd_req    = (state == ARB_GRANT_I) ? i_bus.req :
                      (state == ARB_GRANT_D) ? d_bus.req : 1'b0;
  assign accept     = fwd_req & m_bus.addr_ok;
  assign push_owner = (state == ARB_GRANT_D) ? OWN_D : OWN_I;
  assign pop        = m_bus.data_ok & ~fifo_empty;

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_owner (push_owner),
    .pop        (pop),
    .head_owner (head_owner),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWN_D;
      proto_err  <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= push_owner;
      end
      if (m_bus.data_ok && fifo_empty) begin
        proto_err <= 1'b1;
      end
    end
  end

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (!fifo_full && (i_bus.req || d_bus.req)) begin
          if (i_bus.req && d_bus.req) begin
            state_nxt = (last_grant == OWN_D) ? ARB_GRANT_I : ARB_GRANT_D;
          end else if (i_bus.req) begin
            state_nxt = ARB_GRANT_I;
          end else begin
            state_nxt = ARB_GRANT_D;
          end
        end
      end
      ARB_GRANT_I: begin
        if (accept || !i_bus.req) begin
          state_nxt = ARB_IDLE;
        end
      end
      ARB_GRANT_D: begin
        if (accept || !d_bus.req) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_bus.req     = fwd_req;
    m_bus.wr      = 1'b0;
    m_bus.size    = 2'd0;
    m_bus.addr    = {ADDR_W{1'b0}};
    m_bus.wdata   = {DATA_W{1'b0}};
    i_bus.addr_ok = 1'b0;
    d_bus.addr_ok = 1'b0;
    case (state)
      ARB_GRANT_I: begin
        m_bus.size    = SIZE_WORD;
        m_bus.addr    = i_bus.addr;
        i_bus.addr_ok = accept;
      end
      ARB_GRANT_D: begin
        m_bus.wr      = d_bus.wr;
        m_bus.size    = d_bus.size;
        m_bus.addr    = d_bus.addr;
        m_bus.wdata   = d_bus.wdata;
        d_bus.addr_ok = accept;
      end
      default: begin
        m_bus.req = 1'b0;
      end
    endcase
  end

  assign i_bus.data_ok = pop & (head_owner == OWN_I);
  assign d_bus.data_ok = pop & (head_owner == OWN_D);
  assign i_bus.rdata   = m_bus.rdata;
  assign d_bus.rdata   = m_bus.rdata;

  assign busy = (state != ARB_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  import cache_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic proto_err;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ib ();
  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) db ();
  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb ();

  cache_mem_arbiter #(
    .MAX_OUTSTANDING (4),
    .ADDR_W          (32),
    .DATA_W          (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_bus     (ib),
    .d_bus     (db),
    .m_bus     (mb),
    .busy      (busy),
    .proto_err (proto_err)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  owner_e exp_q[$];
  owner_e model_last;

  task automatic clear_inputs();
    ib.req = 0; ib.wr = 0; ib.size = 0; ib.addr = 0; ib.wdata = 0;
    db.req = 0; db.wr = 0; db.size = 0; db.addr = 0; db.wdata = 0;
    mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_last = OWN_D;
  endtask

  // Single uncontended request: decide cycle, accept cycle, back to idle.
  task automatic issue_single(input bit is_d, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
    owner_e o;
    o = is_d ? OWN_D : OWN_I;
    if (is_d) begin
      db.req = 1; db.wr = wr; db.size = size; db.addr = addr; db.wdata = wdata;
    end else begin
      ib.req = 1; ib.addr = addr;
    end
    #1;
    n_checks++;
    if (mb.req !== 1'b0) begin n_fail++; $display("FAIL issue_idle_req got=%b exp=0", mb.req); end
    @(negedge clk);
    mb.addr_ok = 1;
    #1;
    n_checks++;
    if (mb.req !== 1'b1 || mb.addr !== addr) begin
      n_fail++; $display("FAIL issue_fwd req=%b addr=%h exp_addr=%h", mb.req, mb.addr, addr);
    end
    n_checks++;
    if (mb.wr !== (is_d ? wr : 1'b0) || mb.size !== (is_d ? size : SIZE_WORD) ||
        mb.wdata !== (is_d ? wdata : 32'h0)) begin
      n_fail++; $display("FAIL issue_fields wr=%b size=%0d wdata=%h", mb.wr, mb.size, mb.wdata);
    end
    n_checks++;
    if (ib.addr_ok !== !is_d || db.addr_ok !== is_d) begin
      n_fail++; $display("FAIL issue_addr_ok i=%b d=%b exp_d=%b", ib.addr_ok, db.addr_ok, is_d);
    end
    exp_q.push_back(o);
    model_last = o;
    @(negedge clk);
    ib.req = 0; db.req = 0; mb.addr_ok = 0;
    #1;
    n_checks++;
    if (mb.req !== 1'b0) begin n_fail++; $display("FAIL issue_release_req got=%b exp=0", mb.req); end
  endtask

  task automatic expect_response(input logic [31:0] rdata);
    owner_e o;
    mb.data_ok = 1; mb.rdata = rdata;
    #1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL resp_scoreboard_empty i_ok=%b d_ok=%b", ib.data_ok, db.data_ok);
    end else begin
      o = exp_q.pop_front();
      if (ib.data_ok !== (o == OWN_I) || db.data_ok !== (o == OWN_D)) begin
        n_fail++; $display("FAIL resp_route i_ok=%b d_ok=%b exp_owner=%0d", ib.data_ok, db.data_ok, o);
      end
    end
    n_checks++;
    if (ib.rdata !== rdata || db.rdata !== rdata) begin
      n_fail++; $display("FAIL resp_rdata i=%h d=%h exp=%h", ib.rdata, db.rdata, rdata);
    end
    @(negedge clk);
    mb.data_ok = 0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (mb.req !== 0 || busy !== 0 || proto_err !== 0 || mb.addr !== 0 || mb.wdata !== 0 ||
        ib.addr_ok !== 0 || db.addr_ok !== 0 || ib.data_ok !== 0 || db.data_ok !== 0) begin
      n_fail++;
      $display("FAIL reset_state req=%b busy=%b perr=%b addr=%h wdata=%h", mb.req, busy, proto_err, mb.addr, mb.wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    issue_single(1'b0, 1'b0, 2'd0, 32'h1FC0_0000, 32'h0);
    n_checks++;
    if (busy !== 1'b1 || db.data_ok !== 1'b0) begin
      n_fail++; $display("FAIL single_busy busy=%b d_ok=%b", busy, db.data_ok);
    end
    @(negedge clk);
    expect_response(32'hDEAD_BEEF);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_alternate();
    owner_e o;
    do_reset();
    ib.req = 1; ib.addr = 32'h100;
    db.req = 1; db.addr = 32'h200; db.size = 2'd2;
    mb.addr_ok = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if (k % 2 == 0) begin
        if (mb.req !== 1'b0) begin n_fail++; $display("FAIL alt_idle k=%0d req=%b", k, mb.req); end
      end else begin
        o = (model_last == OWN_D) ? OWN_I : OWN_D;
        if (mb.req !== 1'b1 || ib.addr_ok !== (o == OWN_I) || db.addr_ok !== (o == OWN_D) ||
            mb.addr !== ((o == OWN_I) ? 32'h100 : 32'h200)) begin
          n_fail++;
          $display("FAIL alt_grant k=%0d req=%b i_ok=%b d_ok=%b addr=%h exp_owner=%0d", k, mb.req, ib.addr_ok, db.addr_ok, mb.addr, o);
        end
        exp_q.push_back(o);
        model_last = o;
      end
      @(negedge clk);
    end
    ib.req = 0; db.req = 0; mb.addr_ok = 0;
    for (int k = 0; k < 4; k++) expect_response(32'hA000 + k);
  endtask

  task automatic test_fifo_full();
    do_reset();
    ib.req = 1; ib.addr = 32'h300;
    mb.addr_ok = 1;
    for (int k = 0; k < 11; k++) begin
      #1;
      n_checks++;
      if (k < 8 && k % 2 == 1) begin
        if (mb.req !== 1'b1 || ib.addr_ok !== 1'b1) begin
          n_fail++; $display("FAIL full_grant k=%0d req=%b i_ok=%b", k, mb.req, ib.addr_ok);
        end
        exp_q.push_back(OWN_I);
      end else if (mb.req !== 1'b0) begin
        n_fail++; $display("FAIL full_stall k=%0d req=%b exp=0", k, mb.req);
      end
      @(negedge clk);
    end
    expect_response(32'h11);
    n_checks++;
    if (mb.req !== 1'b0) begin n_fail++; $display("FAIL full_resume_early req=%b exp=0", mb.req); end
    @(negedge clk);
    #1;
    n_checks++;
    if (mb.req !== 1'b1 || ib.addr_ok !== 1'b1) begin
      n_fail++; $display("FAIL full_resume req=%b i_ok=%b exp=1", mb.req, ib.addr_ok);
    end
    exp_q.push_back(OWN_I);
    @(negedge clk);
    ib.req = 0; mb.addr_ok = 0;
    for (int k = 0; k < 4; k++) expect_response(32'h20 + k);
  endtask

  task automatic test_in_order();
    do_reset();
    issue_single(1'b0, 1'b0, 2'd0, 32'h400, 32'h0);
    issue_single(1'b1, 1'b0, 2'd2, 32'h500, 32'h0);
    issue_single(1'b0, 1'b0, 2'd0, 32'h404, 32'h0);
    expect_response(32'd1);
    expect_response(32'd2);
    expect_response(32'd3);
  endtask

  task automatic test_write_with_pop();
    owner_e o;
    do_reset();
    issue_single(1'b0, 1'b0, 2'd0, 32'h600, 32'h0);
    db.req = 1; db.wr = 1; db.size = 2'd0; db.addr = 32'h8000_0003; db.wdata = 32'hAB;
    @(negedge clk);
    mb.addr_ok = 1; mb.data_ok = 1; mb.rdata = 32'h77;
    #1;
    n_checks++;
    if (mb.wr !== 1'b1 || mb.size !== 2'd0 || mb.addr !== 32'h8000_0003 || mb.wdata !== 32'hAB) begin
      n_fail++; $display("FAIL wpop_fields wr=%b size=%0d addr=%h wdata=%h", mb.wr, mb.size, mb.addr, mb.wdata);
    end
    n_checks++;
    if (db.addr_ok !== 1'b1 || ib.addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL wpop_addr_ok d=%b i=%b", db.addr_ok, ib.addr_ok);
    end
    o = exp_q.pop_front();
    n_checks++;
    if (ib.data_ok !== (o == OWN_I) || db.data_ok !== (o == OWN_D) || ib.rdata !== 32'h77) begin
      n_fail++; $display("FAIL wpop_route i_ok=%b d_ok=%b rdata=%h exp_owner=%0d", ib.data_ok, db.data_ok, ib.rdata, o);
    end
    exp_q.push_back(OWN_D);
    @(negedge clk);
    db.req = 0; mb.addr_ok = 0; mb.data_ok = 0;
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL wpop_count busy=%b exp=1", busy); end
    expect_response(32'h88);
    n_checks++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL wpop_drain busy=%b perr=%b exp=0", busy, proto_err);
    end
  endtask

  task automatic test_proto_err_and_reset();
    do_reset();
    mb.data_ok = 1; mb.rdata = 32'h99;
    #1;
    n_checks++;
    if (ib.data_ok !== 0 || db.data_ok !== 0 || proto_err !== 0) begin
      n_fail++; $display("FAIL perr_no_route i_ok=%b d_ok=%b perr=%b", ib.data_ok, db.data_ok, proto_err);
    end
    @(negedge clk);
    mb.data_ok = 0;
    #1;
    n_checks++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_set got=%b exp=1", proto_err); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
    db.req = 1; db.wr = 1; db.addr = 32'h700; db.wdata = 32'h12; db.size = 2'd2;
    @(negedge clk);
    #1;
    n_checks++;
    if (mb.req !== 1'b1 || mb.addr !== 32'h700) begin
      n_fail++; $display("FAIL rst_pre_grant req=%b addr=%h", mb.req, mb.addr);
    end
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (mb.req !== 0 || busy !== 0 || proto_err !== 0 || mb.addr !== 0 || mb.wdata !== 0 ||
        ib.addr_ok !== 0 || db.addr_ok !== 0 || ib.data_ok !== 0 || db.data_ok !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_grant req=%b busy=%b perr=%b addr=%h wdata=%h", mb.req, busy, proto_err, mb.addr, mb.wdata);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_last = OWN_D;
    test_reset();
    test_single_read();
    test_alternate();
    test_fifo_full();
    test_in_order();
    test_write_with_pop();
    test_proto_err_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
